serializer_tx_param: RTL and testbench
======================================

// Module: serializer_tx_param
// PURPOSE
//  Parametrised parallel-to-serial transmitter for the PHY TX path.
//  Serialises DATA_W-bit words onto a 1-bit line, one bit per clock, with a valid/ready handshake and a 1-entry holding buffer.
//  Inserts the IDLE_SYM symbol whenever no data is pending, and emits INIT_IDLES idle symbols after reset before accepting data.
//  Keeps saturating counters of idle and data words sent.
// PARAMETERS
//  DATA_W      8      symbol width in bits (>=2)
//  IDLE_SYM    8'hBC  idle/COM symbol sent when no data is pending (DATA_W bits)
//  MSB_FIRST   1      1: bit DATA_W-1 sent first; 0: bit 0 sent first
//  INIT_IDLES  4      idle symbols sent after reset before ready may assert (0 allowed)
//  CNT_W       16     width of the statistics counters
// PORTS
//  clock         in   1        bit-rate clock; all logic on posedge
//  reset         in   1        asynchronous, active-high reset
//  data_in       in   DATA_W   parallel word from the transaction layer
//  valid         in   1        data_in holds a word; transfer when valid && ready
//  ready         out  1        holding buffer can accept a word this cycle
//  clear_cnt     in   1        synchronous clear of both counters
//  data_out      out  1        serial output bit (registered)
//  data2sent     out  DATA_W   word currently being shifted (data or IDLE_SYM)
//  in_sync       out  1        init idle sequence finished (state RUN)
//  counter_idle  out  CNT_W    idle symbols loaded, saturating
//  counter_data  out  CNT_W    data words loaded, saturating
// BEHAVIOUR
//  - Reset (async): data_out=0, data2sent=0, in_sync=0, counters=0, hold_v=0, init_cnt=0, bit_idx=DATA_W-1, state=INIT.
//    Any partial word and the held word are discarded; the line restarts at a symbol boundary.
//  - Load edge: the edge where bit_idx==DATA_W-1. The first edge after reset release is a load edge.
//    On a load edge: bit_idx<=0; shreg and data2sent <= next word; data_out <= first bit of that word.
//    On every other edge: bit_idx++; data_out <= next bit (MSB_FIRST order).
//    Each word therefore occupies data_out for exactly DATA_W consecutive cycles.
//  - Next word selection: if state==RUN && hold_v, the held word (hold_v cleared unless refilled in the same cycle); otherwise IDLE_SYM.
//  - FSM: INIT -> RUN; RUN is terminal until reset.
//    INIT: only IDLE_SYM is loaded; init_cnt increments on each load edge.
//    On the load edge that loads idle number INIT_IDLES: state<=RUN, in_sync<=1.
//    If INIT_IDLES==0, the first load edge already loads from the RUN rule (hold is empty, so the word is IDLE_SYM) and sets in_sync.
//  - ready = (state==RUN) && (!hold_v || (load edge now && hold_v)). Combinational from state, hold_v and bit_idx.
//  - Accept (valid && ready): hold<=data_in, hold_v<=1.
//    Accept on the same load edge that drains hold: old word goes to shreg, new word goes to hold, hold_v stays 1.
//    A word accepted on a load edge while hold was empty is not loaded at that edge; IDLE_SYM is loaded and the word goes out at the next boundary.
//  - Latency: a word accepted at edge k (hold empty) appears on data_out from the first load edge after k.
//    Worst case DATA_W cycles, best case 1 cycle.
//  - valid with ready=0: no transfer and no state change. The source must hold data_in stable until ready.
//  - Counters: on each load edge, +1 to counter_idle (IDLE_SYM loaded) or counter_data (data loaded), including INIT idles.
//    Saturate at all-ones, no wrap. clear_cnt has priority over a simultaneous increment (result 0).
//  - A data word equal to IDLE_SYM counts as data.
// STRUCTURE
//  - Shared package phy_pcie_pkg: FSM state encoding (ST_INIT, ST_RUN), default idle symbol K28_5_SYM=8'hBC.
//  - One sub-module, sat_counter #(CNT_W): inc, clr, q. Instantiated twice.
//  - The remaining datapath (hold register, shifter, bit_idx, FSM) stays in this module.
// TESTING
//  1. DATA_W=8, INIT_IDLES=4, valid=0: data_out repeats 1,0,1,1,1,1,0,0; ready=0 until the edge loading idle #4 (edge 25 after reset).
//     in_sync=1 from edge 25; counter_idle=4 at edge 25.
//  2. After sync, send 8'hA5 with MSB_FIRST=1: next symbol on data_out = 1,0,1,0,0,1,0,1; data2sent=8'hA5; counter_data +1.
//     Repeat with MSB_FIRST=0: bits 1,0,1,0,0,1,0,1 LSB-first (= 8'hA5 reversed order); verify order.
//  3. Back-to-back stream 8'h01,8'h02,8'h03 with valid held high: no IDLE_SYM between words; ready low for the 7 non-load cycles while hold is full.
//  4. Assert reset at bit 3 of a data word with hold full: data_out=0, data2sent=0, counters=0, ready=0 immediately.
//     After release, INIT restarts with 4 idles.
//  5. CNT_W=4, idle only for 20 symbols: counter_idle stops at 4'hF.
//     clear_cnt asserted on a load edge: counter_idle=0 (not 1).
//  6. INIT_IDLES=0, DATA_W=16, IDLE_SYM=16'hBCBC: in_sync=1 at the first edge; a word accepted at edge 2 starts on data_out at edge 17.

Source files
------------

// File: rtl/phy_pcie_pkg.sv
// Shared definitions for the PHY TX path: FSM encoding and the default idle symbol.
package phy_pcie_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } tx_state_e;

  localparam logic [7:0] K28_5_SYM = 8'hBC;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides the increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != {CNT_W{1'b1}})) begin
      r_q <= r_q + CNT_W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serializer_tx_param.sv
// Parallel-to-serial PHY transmitter: one bit per clock, 1-entry holding buffer,
// idle-symbol fill, post-reset idle training and saturating word statistics.
module serializer_tx_param
  import phy_pcie_pkg::*;
#(
  parameter int unsigned       DATA_W     = 8,
  parameter logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(K28_5_SYM),
  parameter bit                MSB_FIRST  = 1'b1,
  parameter int unsigned       INIT_IDLES = 4,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_clear_cnt,
  output logic              o_data_out,
  output logic [DATA_W-1:0] o_data2sent,
  output logic              o_in_sync,
  output logic [CNT_W-1:0]  o_counter_idle,
  output logic [CNT_W-1:0]  o_counter_data
);

  localparam int unsigned IDX_W  = $clog2(DATA_W);
  localparam int unsigned INIT_W = $clog2(INIT_IDLES + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_e         r_state;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_data2sent;
  logic              r_hold_v;
  logic              r_data_out;
  logic              r_in_sync;
  logic [INIT_W-1:0] r_init_cnt;
  logic [IDX_W-1:0]  r_bit_idx;

  logic              w_load;
  logic              w_run;
  logic              w_take_hold;
  logic              w_accept;
  logic              w_last_init;
  logic              w_inc_idle;
  logic [DATA_W-1:0] w_next_word;
  logic [INIT_W-1:0] w_init_nxt;

  assign w_load      = (r_bit_idx == LAST_IDX);
  assign w_run       = (r_state == ST_RUN);
  assign w_take_hold = w_load && w_run && r_hold_v;
  // A full buffer frees up exactly on the edge that drains it into the shifter.
  assign o_ready     = w_run && (!r_hold_v || w_load);
  assign w_accept    = i_valid && o_ready;
  assign w_next_word = w_take_hold ? r_hold : IDLE_SYM;
  assign w_init_nxt  = r_init_cnt + INIT_W'(1);
  assign w_last_init = (INIT_IDLES == 0) || (w_init_nxt == INIT_W'(INIT_IDLES));
  assign w_inc_idle  = w_load && !w_take_hold;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_INIT;
      r_hold      <= '0;
      r_hold_v    <= 1'b0;
      r_shreg     <= '0;
      r_data2sent <= '0;
      r_data_out  <= 1'b0;
      r_in_sync   <= 1'b0;
      r_init_cnt  <= '0;
      r_bit_idx   <= LAST_IDX;
    end else begin
      if (w_load) begin
        r_bit_idx   <= '0;
        r_shreg     <= w_next_word;
        r_data2sent <= w_next_word;
        r_data_out  <= MSB_FIRST ? w_next_word[DATA_W-1] : w_next_word[0];
        if (r_state == ST_INIT) begin
          r_init_cnt <= w_init_nxt;
          if (w_last_init) begin
            r_state   <= ST_RUN;
            r_in_sync <= 1'b1;
          end
        end
      end else begin
        r_bit_idx <= r_bit_idx + IDX_W'(1);
        if (MSB_FIRST) begin
          r_data_out <= r_shreg[DATA_W-2];
          r_shreg    <= r_shreg << 1;
        end else begin
          r_data_out <= r_shreg[1];
          r_shreg    <= r_shreg >> 1;
        end
      end

      if (w_accept) begin
        r_hold   <= i_data_in;
        r_hold_v <= 1'b1;
      end else if (w_take_hold) begin
        r_hold_v <= 1'b0;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_idle (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_inc  (w_inc_idle),
    .i_clr  (i_clear_cnt),
    .o_q    (o_counter_idle)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_data (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_inc  (w_take_hold),
    .i_clr  (i_clear_cnt),
    .o_q    (o_counter_data)
  );

  assign o_data_out  = r_data_out;
  assign o_data2sent = r_data2sent;
  assign o_in_sync   = r_in_sync;

endmodule

// File: tb/tb_serializer_tx_param.sv
// Bench for serializer_tx_param: three configurations checked against a symbol-level stream model.
module tb_serializer_tx_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sel = 2'd0;
  logic        tb_valid = 1'b0;
  logic        tb_clr = 1'b0;
  logic [15:0] tb_data = '0;

  always #5 clk = ~clk;

  logic rdy0, out0, sync0, rdy1, out1, sync1, rdy2, out2, sync2;
  logic [7:0]  w0, w1;
  logic [15:0] w2, ci0, cd0, ci2, cd2;
  logic [3:0]  ci1, cd1;

  serializer_tx_param #(
    .DATA_W(8), .IDLE_SYM(8'hBC), .MSB_FIRST(1'b1), .INIT_IDLES(4), .CNT_W(16)
  ) u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_data_in(tb_data[7:0]), .i_valid(tb_valid && (sel == 2'd0)),
    .o_ready(rdy0), .i_clear_cnt(tb_clr && (sel == 2'd0)), .o_data_out(out0), .o_data2sent(w0),
    .o_in_sync(sync0), .o_counter_idle(ci0), .o_counter_data(cd0)
  );

  serializer_tx_param #(
    .DATA_W(8), .IDLE_SYM(8'hBC), .MSB_FIRST(1'b0), .INIT_IDLES(4), .CNT_W(4)
  ) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_data_in(tb_data[7:0]), .i_valid(tb_valid && (sel == 2'd1)),
    .o_ready(rdy1), .i_clear_cnt(tb_clr && (sel == 2'd1)), .o_data_out(out1), .o_data2sent(w1),
    .o_in_sync(sync1), .o_counter_idle(ci1), .o_counter_data(cd1)
  );

  serializer_tx_param #(
    .DATA_W(16), .IDLE_SYM(16'hBCBC), .MSB_FIRST(1'b1), .INIT_IDLES(0), .CNT_W(16)
  ) u_dut2 (
    .i_clock(clk), .i_reset(rst), .i_data_in(tb_data), .i_valid(tb_valid && (sel == 2'd2)),
    .o_ready(rdy2), .i_clear_cnt(tb_clr && (sel == 2'd2)), .o_data_out(out2), .o_data2sent(w2),
    .o_in_sync(sync2), .o_counter_idle(ci2), .o_counter_data(cd2)
  );

  logic        obs_ready, obs_out, obs_sync;
  logic [15:0] obs_word, obs_ci, obs_cd;
  logic [49:0] obs_vec;

  always_comb begin
    obs_ready = 1'b0; obs_out = 1'b0; obs_sync = 1'b0;
    obs_word = '0; obs_ci = '0; obs_cd = '0;
    case (sel)
      2'd0: begin
        obs_ready = rdy0; obs_out = out0; obs_sync = sync0;
        obs_word = {8'h00, w0}; obs_ci = ci0; obs_cd = cd0;
      end
      2'd1: begin
        obs_ready = rdy1; obs_out = out1; obs_sync = sync1;
        obs_word = {8'h00, w1}; obs_ci = {12'h000, ci1}; obs_cd = {12'h000, cd1};
      end
      default: begin
        obs_ready = rdy2; obs_out = out2; obs_sync = sync2;
        obs_word = w2; obs_ci = ci2; obs_cd = cd2;
      end
    endcase
  end

  assign obs_vec = {obs_out, obs_word, obs_sync, obs_ci, obs_cd};

  int total = 0;
  int bad = 0;

  // Stream model: the line is a sequence of DATA_W-cycle symbols numbered from reset.
  int          m_dw, m_init, m_cmax, m_n, m_ci, m_cd;
  bit          m_msb, m_sync, m_out;
  logic [15:0] m_idle, m_word;
  logic [15:0] pend[$];
  logic [15:0] txq[$];
  logic        er;
  bit          acc;

  task automatic model_reset();
    m_n = 0; m_sync = 1'b0; m_out = 1'b0; m_word = '0; m_ci = 0; m_cd = 0;
    pend.delete();
  endtask

  function automatic logic model_ready();
    return m_sync && ((pend.size() == 0) || ((m_n % m_dw) == 0));
  endfunction

  function automatic logic [49:0] exp_vec();
    return {m_out, m_word, m_sync, 16'(m_ci), 16'(m_cd)};
  endfunction

  task automatic model_edge(input bit acc_i, input logic [15:0] din, input bit clr);
    bit          was_sync, inc_i, inc_d;
    int          p;
    logic [15:0] msk;
    was_sync = m_sync; inc_i = 1'b0; inc_d = 1'b0;
    m_n++;
    p = (m_n - 1) % m_dw;
    if (p == 0) begin
      if (was_sync && pend.size() > 0) begin
        m_word = pend.pop_front(); inc_d = 1'b1;
      end else begin
        m_word = m_idle; inc_i = 1'b1;
      end
      if (((m_n - 1) / m_dw) >= m_init - 1) m_sync = 1'b1;
    end
    if (clr) begin
      m_ci = 0; m_cd = 0;
    end else begin
      if (inc_i && m_ci < m_cmax) m_ci++;
      if (inc_d && m_cd < m_cmax) m_cd++;
    end
    msk = 16'((32'd1 << m_dw) - 1);
    if (acc_i) pend.push_back(din & msk);
    m_out = m_msb ? m_word[m_dw-1-p] : m_word[p];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int s);
    sel = 2'(s); tb_valid = 1'b0; tb_clr = 1'b0;
    case (s)
      0:       begin m_dw = 8;  m_msb = 1'b1; m_init = 4; m_cmax = 65535; m_idle = 16'h00BC; end
      1:       begin m_dw = 8;  m_msb = 1'b0; m_init = 4; m_cmax = 15;    m_idle = 16'h00BC; end
      default: begin m_dw = 16; m_msb = 1'b1; m_init = 0; m_cmax = 65535; m_idle = 16'hBCBC; end
    endcase
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset(0);
    rst = 1'b1;
    #1;
    total++;
    if ({obs_vec, obs_ready} !== 51'd0) begin
      bad++; $display("FAIL reset_values got=%h ready=%b want=all zero", obs_vec, obs_ready);
    end
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_init(input bit do_rst);
    if (do_rst) apply_reset(0);
    for (int c = 0; c < 40; c++) begin
      er = model_ready();
      total++;
      if (obs_ready !== er) begin
        bad++; $display("FAIL init_ready n=%0d got=%b want=%b", m_n, obs_ready, er);
      end
      acc = tb_valid && er;
      tick();
      model_edge(acc, tb_data, tb_clr);
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++; $display("FAIL init_outputs n=%0d got=%h want=%h", m_n, obs_vec, exp_vec());
      end
      if (m_n == 24 || m_n == 25) begin
        total++;
        if ({obs_sync, obs_ci} !== {m_n == 25, 16'(m_n == 25 ? 4 : 3)}) begin
          bad++; $display("FAIL init_sync_edge n=%0d got sync=%b idle=%0d", m_n, obs_sync, obs_ci);
        end
      end
    end
  endtask

  task automatic test_word(input int s, input logic [7:0] w);
    logic [7:0] bits;
    bits = '0;
    apply_reset(s);
    txq.delete(); txq.push_back({8'h00, w});
    for (int c = 0; c < 60; c++) begin
      if (!tb_valid && txq.size() > 0 && m_sync) begin
        tb_valid = 1'b1; tb_data = txq.pop_front();
      end
      er = model_ready();
      total++;
      if (obs_ready !== er) begin
        bad++; $display("FAIL word_ready n=%0d got=%b want=%b", m_n, obs_ready, er);
      end
      acc = tb_valid && er;
      tick();
      model_edge(acc, tb_data, tb_clr);
      if (acc) tb_valid = 1'b0;
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++; $display("FAIL word_outputs n=%0d got=%h want=%h", m_n, obs_vec, exp_vec());
      end
      if (m_n >= 33 && m_n <= 40) bits = {bits[6:0], obs_out};
    end
    total++;
    if (bits !== (s == 0 ? w : {<<{w}})) begin
      bad++; $display("FAIL word_bit_order got=%h want word=%h msb_first=%0d", bits, w, s == 0);
    end
    total++;
    if (obs_cd !== 16'd1) begin
      bad++; $display("FAIL word_data_count got=%0d want=1", obs_cd);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset(0);
    txq.delete(); txq.push_back(16'h01); txq.push_back(16'h02); txq.push_back(16'h03);
    for (int c = 0; c < 70; c++) begin
      if (!tb_valid && txq.size() > 0 && m_sync) begin
        tb_valid = 1'b1; tb_data = txq.pop_front();
      end
      er = model_ready();
      total++;
      if (obs_ready !== er) begin
        bad++; $display("FAIL b2b_ready n=%0d got=%b want=%b", m_n, obs_ready, er);
      end
      acc = tb_valid && er;
      tick();
      model_edge(acc, tb_data, tb_clr);
      if (acc) begin
        if (txq.size() > 0) tb_data = txq.pop_front();
        else tb_valid = 1'b0;
      end
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++; $display("FAIL b2b_outputs n=%0d got=%h want=%h", m_n, obs_vec, exp_vec());
      end
    end
    total++;
    if ({obs_cd, obs_ci} !== {16'd3, 16'd6}) begin
      bad++; $display("FAIL b2b_counts got data=%0d idle=%0d want data=3 idle=6", obs_cd, obs_ci);
    end
  endtask

  task automatic test_reset_midword();
    bit hit;
    hit = 1'b0;
    apply_reset(0);
    txq.delete(); txq.push_back(16'h11); txq.push_back(16'h22);
    for (int c = 0; c < 80 && !hit; c++) begin
      if (!tb_valid && txq.size() > 0 && m_sync) begin
        tb_valid = 1'b1; tb_data = txq.pop_front();
      end
      er = model_ready();
      acc = tb_valid && er;
      tick();
      model_edge(acc, tb_data, tb_clr);
      if (acc) begin
        if (txq.size() > 0) tb_data = txq.pop_front();
        else tb_valid = 1'b0;
      end
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++; $display("FAIL midrst_outputs n=%0d got=%h want=%h", m_n, obs_vec, exp_vec());
      end
      hit = (m_word == 16'h11) && (((m_n - 1) % 8) == 3) && (pend.size() == 1);
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL midrst_reach got=timeout want=bit3 of word 11 with hold full");
    end
    tb_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({obs_vec, obs_ready} !== 51'd0) begin
      bad++; $display("FAIL midrst_async got=%h ready=%b want=all zero", obs_vec, obs_ready);
    end
    #1;
    rst = 1'b0;
    model_reset();
    test_init(1'b0);
  endtask

  task automatic test_saturate();
    apply_reset(1);
    for (int c = 0; c < 160; c++) begin
      er = model_ready();
      total++;
      if (obs_ready !== er) begin
        bad++; $display("FAIL sat_ready n=%0d got=%b want=%b", m_n, obs_ready, er);
      end
      tick();
      model_edge(1'b0, tb_data, 1'b0);
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++; $display("FAIL sat_outputs n=%0d got=%h want=%h", m_n, obs_vec, exp_vec());
      end
    end
    total++;
    if (obs_ci !== 16'd15) begin
      bad++; $display("FAIL sat_stop got=%0d want=15", obs_ci);
    end
    tb_clr = 1'b1;
    tick();
    model_edge(1'b0, tb_data, 1'b1);
    tb_clr = 1'b0;
    total++;
    if (obs_ci !== 16'd0 || (m_n % 8) != 1) begin
      bad++; $display("FAIL sat_clear_on_load got=%0d want=0", obs_ci);
    end
    total++;
    if (obs_vec !== exp_vec()) begin
      bad++; $display("FAIL sat_clear_outputs got=%h want=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_random(input int s, input int ncyc);
    apply_reset(s);
    for (int c = 0; c < ncyc; c++) begin
      if (!tb_valid && $urandom_range(0, 2) != 0) begin
        tb_valid = 1'b1; tb_data = 16'($urandom);
      end
      tb_clr = ($urandom_range(0, 63) == 0);
      er = model_ready();
      total++;
      if (obs_ready !== er) begin
        bad++; $display("FAIL rand_ready cfg=%0d n=%0d got=%b want=%b", s, m_n, obs_ready, er);
      end
      acc = tb_valid && er;
      tick();
      model_edge(acc, tb_data, tb_clr);
      if (acc) tb_valid = 1'b0;
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++; $display("FAIL rand_outputs cfg=%0d n=%0d got=%h want=%h", s, m_n, obs_vec, exp_vec());
      end
    end
    tb_clr = 1'b0; tb_valid = 1'b0;
  endtask

  task automatic test_noinit();
    logic [15:0] w;
    w = 16'($urandom_range(0, 16'hBCBB));
    apply_reset(2);
    for (int c = 0; c < 40; c++) begin
      if (m_n == 1) begin
        tb_valid = 1'b1; tb_data = w;
      end
      er = model_ready();
      total++;
      if (obs_ready !== er) begin
        bad++; $display("FAIL noinit_ready n=%0d got=%b want=%b", m_n, obs_ready, er);
      end
      acc = tb_valid && er;
      tick();
      model_edge(acc, tb_data, tb_clr);
      if (acc) tb_valid = 1'b0;
      total++;
      if (obs_vec !== exp_vec()) begin
        bad++; $display("FAIL noinit_outputs n=%0d got=%h want=%h", m_n, obs_vec, exp_vec());
      end
      if (m_n == 1) begin
        total++;
        if (obs_sync !== 1'b1) begin
          bad++; $display("FAIL noinit_sync got=%b want=1", obs_sync);
        end
      end
      if (m_n == 17) begin
        total++;
        if ({obs_word, obs_out} !== {w, w[15]}) begin
          bad++; $display("FAIL noinit_start got=%h/%b want=%h/%b", obs_word, obs_out, w, w[15]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init(1'b1);
    test_word(0, 8'hA5);
    test_word(1, 8'hA5);
    test_word(1, 8'h1E);
    test_back_to_back();
    test_reset_midword();
    test_saturate();
    test_random(0, 400);
    test_random(1, 400);
    test_random(2, 400);
    test_noinit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
